rom_lookup_arbiter: RTL
=======================

Name: rom_lookup_arbiter

Overview:
- Shares one registered 256x8 lookup ROM among NREQ requesters (phoneme/word-class lookup units in the speech front end).
- Round-robin arbitration, one outstanding ROM access at a time.
- Drives the ROM address and active-low enable, waits the ROM read latency, then returns the byte to the granted requester with a one-cycle ack.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, ROM address width.
- DW, 8, ROM data width.
- ROM_LAT, 1, ROM read latency in CS edges from address applied to data valid (1..4).

Ports:
- CS  in  1  clock, rising-edge active.
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester request level; held high until the matching ack.
- req_addr  in  NREQ*AW  packed addresses, slice i = requester i; stable while req[i] is high.
- ack  out  NREQ  one-cycle pulse; ack[i] means rsp_data is valid for requester i.
- rsp_data  out  DW  returned ROM byte, held until the next ack.
- rom_addr  out  AW  address to the ROM.
- rom_cen  out  1  active-low ROM enable; 0 clears the ROM output register.
- rom_data  in  DW  ROM registered output.
- busy  out  1  high when state is not IDLE.
- served  out  16  count of completed lookups, saturating at 0xFFFF.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - ack, rsp_data, rom_addr, served, rr_ptr and busy all go to 0.
  - rom_cen=0 while rst is high. It goes to 1 on the first CS edge after rst falls.
  - Reset mid-transaction abandons the transaction with no ack.
- FSM states:
  - IDLE: if any eligible req, pick the winner w by round-robin from rr_ptr upward, modulo NREQ. Latch rom_addr <= req_addr[w] and gnt <= w, load wcnt <= ROM_LAT-1, go to WAIT. Otherwise stay.
  - WAIT: if wcnt==0 go to CAPT, else decrement wcnt. rom_addr is held.
  - CAPT: rsp_data <= rom_data, ack[gnt] <= 1 for exactly one cycle. rr_ptr <= (gnt+1) mod NREQ. served increments unless it is 0xFFFF. Go to IDLE.
- Eligibility:
  - In IDLE, requester i is ineligible while ack[i] is high. This prevents a re-grant on the still-high req of the requester just served.
- Latency:
  - Grant at edge E0; ack is high in the cycle after edge E0+ROM_LAT+1.
  - ROM_LAT=1: ack appears 2 edges after the grant edge.
  - Peak throughput is one lookup per ROM_LAT+2 cycles.
- Outputs: ack is one-hot or zero at all times. At most one transaction is outstanding.
- Request withdrawn after grant: the transaction still completes and ack still pulses. The requester ignores it.
- Simultaneous requests: strict rotation. With all NREQ requesters held, the grant order is rr_ptr, rr_ptr+1, and so on, with no requester served twice before the others are served once.
- Address changes on a req line while that requester is granted have no effect; rom_addr is latched.
- rom_cen stays 1 during normal operation. The block never clears the ROM after reset.
- Widths: rom_addr and rsp_data are plain register copies with no arithmetic. served is 16-bit saturating.

Test Plan:
- Reset: rst=1 mid-WAIT -> ack=0, busy=0, rom_cen=0, served=0 immediately. After release, rom_cen=1 on the next edge and the FSM is in IDLE.
- Single lookup: ROM loaded with addr0=0x00, others 0x02, ROM_LAT=1; req[2]=1 with addr 0x05 -> rom_addr=0x05 after the grant edge, ack=4'b0100 with rsp_data=0x02 two edges later. addr 0x00 -> rsp_data=0x00.
- Round robin: req=4'b1111 held continuously, addresses 0x00/0x01/0x02/0x03 -> ack order 0,1,2,3,0 with rsp_data 0x00,0x02,0x02,0x02,0x00. Spacing is 3 cycles between acks; served=5.
- Ack masking: req[1] held one cycle past its ack, req[3] also high -> the next grant goes to 3, not 1.
- Withdrawal and latency: req[0] dropped the cycle after its grant -> ack[0] still pulses once. With ROM_LAT=3, ack arrives 4 edges after the grant.
- Saturation: preload served to 0xFFFE and run 3 lookups -> served=0xFFFF and holds.

Source files
------------

// File: rtl/rom_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// rom_lookup_arbiter
//
// Shares one registered lookup ROM among NREQ requesters (phoneme/word-class
// lookup units). Requests are served one at a time in round-robin order. The
// block drives the ROM address and enable, waits the ROM read latency, then
// returns the byte with a one-cycle ack to the requester that was granted.
//
// Ports:
//   CS         in   clock, rising edge active
//   rst        in   asynchronous reset, active high
//   req        in   [NREQ]     per-requester request level, held until ack
//   req_addr   in   [NREQ*AW]  packed addresses, slice i belongs to requester i
//   ack        out  [NREQ]     one-cycle pulse, rsp_data valid for that requester
//   rsp_data   out  [DW]       returned ROM byte, held until the next ack
//   rom_addr   out  [AW]       ROM address, latched at grant
//   rom_cen    out             active-low ROM enable (low only while in reset)
//   rom_data   in   [DW]       ROM registered output
//   busy       out             high while a lookup is in flight
//   served     out  [16]       completed lookups, saturating at 0xFFFF
//
// SERVED_RST is the reset value of the served counter (0 in normal use).
// -----------------------------------------------------------------------------
module rom_lookup_arbiter #(
  parameter int          NREQ       = 4,
  parameter int          AW         = 8,
  parameter int          DW         = 8,
  parameter int          ROM_LAT    = 1,
  parameter logic [15:0] SERVED_RST = 16'h0000
) (
  input  logic                 CS,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rsp_data,
  output logic [AW-1:0]        rom_addr,
  output logic                 rom_cen,
  input  logic [DW-1:0]        rom_data,
  output logic                 busy,
  output logic [15:0]          served
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t             state_q;
  logic [NREQ-1:0]    ack_q;
  logic [DW-1:0]      rsp_q;
  logic [AW-1:0]      rom_addr_q;
  logic               rom_cen_q;
  logic               busy_q;
  logic [15:0]        served_q;
  logic [15:0]        served_d;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      gnt_q;
  logic [CW-1:0]      wcnt_q;

  logic [NREQ-1:0]    elig;
  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;

  // (base + off) mod NREQ, for NREQ that need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // The requester currently being acked still has req high; masking it stops
  // an immediate second grant for the same lookup.
  assign elig = req & ~ack_q;

  // Round-robin pick: scan from the highest rotation offset down so the
  // candidate closest to rr_ptr is the last (winning) assignment.
  // NOTE: every variable assigned here gets a default first, otherwise the
  // paths that skip the assignment would infer a latch.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = wrap_add(rr_ptr_q, k);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign served_d = (served_q == 16'hFFFF) ? served_q : served_q + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CS or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      rsp_q      <= '0;
      rom_addr_q <= '0;
      rom_cen_q  <= 1'b0;
      busy_q     <= 1'b0;
      served_q   <= SERVED_RST;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      wcnt_q     <= '0;
    end else begin
      // ROM stays enabled from the first edge after reset onward.
      rom_cen_q <= 1'b1;
      ack_q     <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            rom_addr_q <= req_addr[win_idx*AW +: AW];
            gnt_q      <= win_idx;
            wcnt_q     <= CW'(ROM_LAT - 1);
            busy_q     <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt_q == '0) state_q <= S_CAPT;
          else              wcnt_q  <= wcnt_q - CW'(1);
        end
        S_CAPT: begin
          rsp_q        <= rom_data;
          ack_q[gnt_q] <= 1'b1;
          rr_ptr_q     <= wrap_add(gnt_q, 1);
          served_q     <= served_d;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign rsp_data = rsp_q;
  assign rom_addr = rom_addr_q;
  assign rom_cen  = rom_cen_q;
  assign busy     = busy_q;
  assign served   = served_q;

endmodule
